// File: rtl/series_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : series_ctrl
// Description : Moore control FSM sequencing a series-expansion datapath.
//               Loads x, optionally squares it, then repeatedly forms
//               t <= t*x, t <= t*lut[addr] and accumulates r +/- t until the
//               datapath flags convergence or MAX_TERMS terms are summed.
// Revision    : 1.0 - initial release
// ============================================================================
module series_ctrl #(
    parameter int MAX_TERMS = 8,   // 1..15 terms per run
    parameter int ALT       = 1,   // 1: alternate add/sub, 0: always add
    parameter int SQ        = 1    // 1: square x before the term loop
) (
    input  logic clk,
    input  logic rst,              // asynchronous, active-low
    input  logic start,
    input  logic lt,
    output logic initt,
    output logic initr,
    output logic initc,
    output logic ld_x,
    output logic ld_t,
    output logic ld_r,
    output logic ld_y,
    output logic cnt,
    output logic s2,
    output logic s1,
    output logic s0,
    output logic mode,
    output logic busy,
    output logic done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SQUARE = 3'd2,
        ST_MULX   = 3'd3,
        ST_MULC   = 3'd4,
        ST_ACC    = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Term index of the final term; the run ends after accumulating it.
    localparam logic [3:0] c_LAST_K = 4'(MAX_TERMS - 1);
    localparam logic       c_ALT    = (ALT != 0);
    localparam logic       c_SQ     = (SQ != 0);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_k;
    logic       r_parity;

    // State register; reset forces IDLE immediately so outputs drop at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Term counter and sign parity: cleared on LOAD, stepped once per ACC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k      <= 4'd0;
            r_parity <= 1'b0;
        end else if (r_state == ST_LOAD) begin
            r_k      <= 4'd0;
            r_parity <= 1'b0;
        end else if (r_state == ST_ACC) begin
            r_k      <= r_k + 4'd1;
            r_parity <= ~r_parity;
        end
    end

    // Next-state logic and Moore output decode from the registered state.
    always_comb begin
        w_next = r_state;
        initt  = 1'b0;
        initr  = 1'b0;
        initc  = 1'b0;
        ld_x   = 1'b0;
        ld_t   = 1'b0;
        ld_r   = 1'b0;
        ld_y   = 1'b0;
        cnt    = 1'b0;
        s2     = 1'b0;
        s1     = 1'b0;
        s0     = 1'b0;
        mode   = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                s2     = 1'b1;
                ld_x   = 1'b1;
                ld_y   = 1'b1;
                initt  = 1'b1;
                initr  = 1'b1;
                initc  = 1'b1;
                w_next = c_SQ ? ST_SQUARE : ST_MULX;
            end
            ST_SQUARE: begin
                ld_x   = 1'b1;          // s0=0 selects x*x
                w_next = ST_MULX;
            end
            ST_MULX: begin
                s0     = 1'b1;
                ld_t   = 1'b1;
                w_next = ST_MULC;
            end
            ST_MULC: begin
                s0     = 1'b1;
                s1     = 1'b1;
                ld_t   = 1'b1;
                cnt    = 1'b1;
                w_next = ST_ACC;
            end
            ST_ACC: begin
                ld_r = 1'b1;
                mode = c_ALT & r_parity;
                // lt reflects t as produced by the preceding MULC.
                if (lt || (r_k == c_LAST_K)) w_next = ST_DONE;
                else                         w_next = ST_MULX;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
